rasterizer_control_p: RTL
=========================

RASTERIZER_CONTROL_P -- requirements
Module: rasterizer_control_p

Interface
REQ-001 Parameter SCREEN_W, default 800, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 600, visible height in pixels.
REQ-003 Parameter COORD_W, default 11, signed coordinate width in bits.
REQ-004 Parameter ADDR_W, default 14, vertex memory address width.
REQ-005 Parameter STRIDE, default 4, memory words per vertex (must be ≥2); x at offset 0, y at offset 1, remaining words ignored.
REQ-006 Parameters ORIGIN_X and ORIGIN_Y, defaults 400 and 300, added to every fetched coordinate.
REQ-007 Parameter CLEAR_COLOR, default 8'h01, color driven during a clear pass.
REQ-008 clk  in  1  single clock; all logic on the rising edge.
REQ-009 resetn  in  1  synchronous, active-low reset.
REQ-010 start  in  1  begins a frame when sampled high in IDLE; ignored elsewhere.
REQ-011 clear_en  in  1  sampled with start; 1 = run a full-screen clear pass before triangles.
REQ-012 vertex_count  in  32  total memory words in the frame; sampled with start.
REQ-013 mem_addr  out  ADDR_W  vertex memory read address.
REQ-014 mem_data  in  COORD_W  read data, valid exactly one cycle after mem_addr.
REQ-015 px_x, px_y  out  COORD_W each  current pixel coordinate.
REQ-016 px_valid  out  1 and px_ready  in  1  pixel stream handshake.
REQ-017 px_clear  out  1  high while the clear pass is streaming.
REQ-018 tri_coords  out  6*COORD_W  {V3y,V3x,V2y,V2x,V1y,V1x}, offset-applied.
REQ-019 color  out  8  per-triangle color tag.
REQ-020 bb_w, bb_h  out  COORD_W each  BR minus TL of the active box.
REQ-021 frame_end  out  1  high in IDLE.
REQ-022 tri_count  out  16  triangles rasterized this frame.

Function
REQ-023 States: IDLE, CLEAR, CHECK, FETCH, BBOX_MINMAX, BBOX_MERGE, CLAMP, TEST, WALK.
REQ-024 On start in IDLE: latch vertex_count into remaining, mem_addr←0, color←1, tri_count←0, frame_end←0; go to CLEAR if clear_en, else CHECK.
REQ-025 CLEAR: box (0,0)-(SCREEN_W-1,SCREEN_H-1), px_clear=1, color output = CLEAR_COLOR, walk as in WALK; after the last handshake go to CHECK; color and tri_count are not changed.
REQ-026 CHECK: if remaining ≥ 3*STRIDE go to FETCH; otherwise go to IDLE. Leftover words are never fetched.
REQ-027 FETCH: mem_addr increments by 1 each cycle for 3*STRIDE cycles. Coordinates are captured from mem_data one cycle later and sign-extended plus ORIGIN. remaining decreases by 3*STRIDE. mem_addr then points to the next triangle's first word.
REQ-028 BBOX_MINMAX/BBOX_MERGE: signed min/max of the three x and three y values, one cycle each.
REQ-029 CLAMP (one cycle): clamp each box corner to [0,SCREEN_W-1] × [0,SCREEN_H-1].
REQ-030 TEST: if TL_x==BR_x or TL_y==BR_y, skip the triangle (color and tri_count unchanged) and go to CHECK. Otherwise load bb_w/bb_h, set the pixel to TL, and go to WALK.
REQ-031 WALK: px_valid=1. On px_valid&&px_ready, advance in raster order: x++ until BR_x, then x←TL_x and y++. Without a handshake the pixel holds.
REQ-032 Handshake on (BR_x,BR_y): tri_count++, color++ (255 wraps to 1, never 0), go to CHECK.
REQ-033 px_valid is 0 in every state except CLEAR and WALK; the pixel stream has zero added latency.
REQ-034 tri_coords are stable from the end of FETCH until the next FETCH.
REQ-035 vertex_count < 3*STRIDE: frame returns to IDLE after the optional clear, with tri_count=0.
REQ-036 Arithmetic is signed at COORD_W; overflow of coordinate plus ORIGIN is the caller's responsibility.

Reset
REQ-037 resetn=0 at a clock edge, in any state including mid-WALK, forces IDLE. Outputs: mem_addr=0, px_valid=0, px_clear=0, px_x=px_y=0, color=1, tri_count=0, bb_w=bb_h=0, tri_coords=0, frame_end=1.
REQ-038 The first start is accepted on the first edge after resetn returns high.

Verification
REQ-039 Triangle (0,0),(9,0),(0,4), STRIDE=4, vertex_count=12, clear_en=0, px_ready=1 -> 50 pixels (400..409 × 300..304), color=1, tri_count=1, frame_end rises.
REQ-040 clear_en=1, vertex_count=0 -> 480000 pixels with px_clear=1 and color=CLEAR_COLOR, then IDLE with tri_count=0.
REQ-041 Triangle spanning (-500,-400)..(500,400) -> box clamped to (0,0)-(799,599), bb_w=799, bb_h=599.
REQ-042 Degenerate triangle (all x equal) followed by a valid triangle -> first emits no pixels; second gets color=1, tri_count=1.
REQ-043 px_ready toggled randomly -> pixel sequence is identical to the px_ready=1 case, with no duplicates and no drops; vertex_count=13 -> one triangle only.
REQ-044 256 valid triangles -> color sequence 1..255, then 1; resetn low mid-WALK -> px_valid=0 next cycle and IDLE.

Source files
------------

// File: rtl/rasterizer_control_p.sv
// Rasterizer frame controller: fetches triangles from vertex memory,
// computes a clamped bounding box and streams its pixels in raster order.
module rasterizer_control_p #(
  parameter int          SCREEN_W    = 800,
  parameter int          SCREEN_H    = 600,
  parameter int          COORD_W     = 11,
  parameter int          ADDR_W      = 14,
  parameter int          STRIDE      = 4,
  parameter int          ORIGIN_X    = 400,
  parameter int          ORIGIN_Y    = 300,
  parameter logic [7:0]  CLEAR_COLOR = 8'h01
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   clear_en,
  input  logic [31:0]            vertex_count,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [COORD_W-1:0]     mem_data,
  output logic [COORD_W-1:0]     px_x,
  output logic [COORD_W-1:0]     px_y,
  output logic                   px_valid,
  input  logic                   px_ready,
  output logic                   px_clear,
  output logic [6*COORD_W-1:0]   tri_coords,
  output logic [7:0]             color,
  output logic [COORD_W-1:0]     bb_w,
  output logic [COORD_W-1:0]     bb_h,
  output logic                   frame_end,
  output logic [15:0]            tri_count
);

  typedef logic signed [COORD_W-1:0] crd_t;

  typedef enum logic [3:0] {
    IDLE, CLEAR, CHECK, FETCH, BBOX_MINMAX,
    BBOX_MERGE, CLAMP, TEST, WALK
  } state_t;

  localparam crd_t XMAX  = crd_t'(SCREEN_W - 1);
  localparam crd_t YMAX  = crd_t'(SCREEN_H - 1);
  localparam crd_t ORG_X = crd_t'(ORIGIN_X);
  localparam crd_t ORG_Y = crd_t'(ORIGIN_Y);
  localparam crd_t ZERO  = '0;
  localparam int   TRI_WORDS = 3 * STRIDE;

  state_t      state;
  logic [31:0] remaining;
  logic [15:0] fcnt;
  logic [15:0] off;
  logic [1:0]  vtx;
  logic        cap_v;
  logic [15:0] cap_off;
  logic [1:0]  cap_vtx;
  crd_t        vx [3];
  crd_t        vy [3];
  crd_t        tl_x, tl_y, br_x, br_y;
  logic [7:0]  color_q;

  function automatic crd_t smin(crd_t a, crd_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic crd_t smax(crd_t a, crd_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic crd_t clampc(crd_t v, crd_t hi);
    return (v < ZERO) ? ZERO : ((v > hi) ? hi : v);
  endfunction

  assign tri_coords = {vy[2], vx[2], vy[1], vx[1], vy[0], vx[0]};
  assign color      = px_clear ? CLEAR_COLOR : color_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      remaining <= '0;
      fcnt      <= '0;
      off       <= '0;
      vtx       <= '0;
      cap_v     <= 1'b0;
      cap_off   <= '0;
      cap_vtx   <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
      tl_x      <= '0;
      tl_y      <= '0;
      br_x      <= '0;
      br_y      <= '0;
      mem_addr  <= '0;
      px_x      <= '0;
      px_y      <= '0;
      px_valid  <= 1'b0;
      px_clear  <= 1'b0;
      color_q   <= 8'd1;
      bb_w      <= '0;
      bb_h      <= '0;
      frame_end <= 1'b1;
      tri_count <= '0;
    end else begin
      // Read data lags the address by one cycle; track what it belongs to.
      cap_v   <= (state == FETCH);
      cap_off <= off;
      cap_vtx <= vtx;
      if (cap_v && cap_off == 16'd0)
        vx[cap_vtx] <= $signed(mem_data) + ORG_X;
      if (cap_v && cap_off == 16'd1)
        vy[cap_vtx] <= $signed(mem_data) + ORG_Y;

      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= vertex_count;
            mem_addr  <= '0;
            color_q   <= 8'd1;
            tri_count <= '0;
            frame_end <= 1'b0;
            if (clear_en) begin
              tl_x     <= '0;
              tl_y     <= '0;
              br_x     <= XMAX;
              br_y     <= YMAX;
              bb_w     <= XMAX;
              bb_h     <= YMAX;
              px_x     <= '0;
              px_y     <= '0;
              px_valid <= 1'b1;
              px_clear <= 1'b1;
              state    <= CLEAR;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (remaining >= 32'(TRI_WORDS)) begin
            remaining <= remaining - 32'(TRI_WORDS);
            fcnt      <= '0;
            off       <= '0;
            vtx       <= '0;
            state     <= FETCH;
          end else begin
            frame_end <= 1'b1;
            state     <= IDLE;
          end
        end
        FETCH: begin
          mem_addr <= mem_addr + ADDR_W'(1);
          fcnt     <= fcnt + 16'd1;
          if (off == 16'(STRIDE - 1)) begin
            off <= '0;
            vtx <= vtx + 2'd1;
          end else begin
            off <= off + 16'd1;
          end
          if (fcnt == 16'(TRI_WORDS - 1))
            state <= BBOX_MINMAX;
        end
        // V3's last word may land this cycle, so V3 joins in MERGE.
        BBOX_MINMAX: begin
          tl_x  <= smin(vx[0], vx[1]);
          br_x  <= smax(vx[0], vx[1]);
          tl_y  <= smin(vy[0], vy[1]);
          br_y  <= smax(vy[0], vy[1]);
          state <= BBOX_MERGE;
        end
        BBOX_MERGE: begin
          tl_x  <= smin(tl_x, vx[2]);
          br_x  <= smax(br_x, vx[2]);
          tl_y  <= smin(tl_y, vy[2]);
          br_y  <= smax(br_y, vy[2]);
          state <= CLAMP;
        end
        CLAMP: begin
          tl_x  <= clampc(tl_x, XMAX);
          br_x  <= clampc(br_x, XMAX);
          tl_y  <= clampc(tl_y, YMAX);
          br_y  <= clampc(br_y, YMAX);
          state <= TEST;
        end
        TEST: begin
          if (tl_x == br_x || tl_y == br_y) begin
            state <= CHECK;
          end else begin
            bb_w     <= br_x - tl_x;
            bb_h     <= br_y - tl_y;
            px_x     <= tl_x;
            px_y     <= tl_y;
            px_valid <= 1'b1;
            state    <= WALK;
          end
        end
        CLEAR, WALK: begin
          if (px_valid && px_ready) begin
            if (px_x == br_x) begin
              px_x <= tl_x;
              if (px_y == br_y) begin
                px_valid <= 1'b0;
                px_clear <= 1'b0;
                if (state == WALK) begin
                  tri_count <= tri_count + 16'd1;
                  color_q   <= (color_q == 8'd255) ? 8'd1 : color_q + 8'd1;
                end
                state <= CHECK;
              end else begin
                px_y <= px_y + COORD_W'(1);
              end
            end else begin
              px_x <= px_x + COORD_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
